// File: rtl/uart_pkg.sv
// Shared types and constants for the parametrised UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

   localparam logic        UART_LINE_IDLE = 1'b1;
   localparam int unsigned UART_MIN_CPB   = 2;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: latches the bit period on load, pulses bitTick on the
// last clock of every bit period while running.
module uart_baud_counter #(
   parameter int unsigned CPB_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_load,
   input  logic                 i_run,
   input  logic [CPB_WIDTH-1:0] i_cpb,
   output logic                 bitTick
);
   import uart_pkg::*;

   logic [CPB_WIDTH-1:0] r_cpb;
   logic [CPB_WIDTH-1:0] r_cnt;
   logic [CPB_WIDTH-1:0] w_last;
   logic [CPB_WIDTH-1:0] w_cpb_clamped;

   // Periods shorter than the minimum would leave no room for the wrap cycle.
   assign w_cpb_clamped = (i_cpb < CPB_WIDTH'(UART_MIN_CPB)) ? CPB_WIDTH'(UART_MIN_CPB) : i_cpb;
   assign w_last        = r_cpb - CPB_WIDTH'(1);
   assign bitTick       = i_run && (r_cnt == w_last);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cpb <= CPB_WIDTH'(UART_MIN_CPB);
         r_cnt <= '0;
      end else if (i_load) begin
         r_cpb <= w_cpb_clamped;
         r_cnt <= '0;
      end else if (i_run) begin
         r_cnt <= bitTick ? '0 : r_cnt + CPB_WIDTH'(1);
      end
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable width, stop bits and runtime bit period.
// Optional parity support is compiled in with `UART_TX_PARITY_EN.
module uart_tx_frame #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned CPB_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  txDv,
   input  logic [DATA_WIDTH-1:0] txData,
   input  logic [CPB_WIDTH-1:0]  clocksPerBit,
   input  logic                  parityEn,
   input  logic                  parityOdd,
   output logic                  txReady,
   output logic                  txActive,
   output logic                  txDone,
   output logic                  txSerial,
   output logic [DATA_WIDTH-1:0] txByte
);
   import uart_pkg::*;

   localparam int unsigned IdxW = $clog2(DATA_WIDTH);

   uart_tx_state_t        r_state, w_state_d;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_d;
   logic [DATA_WIDTH-1:0] r_byte, w_byte_d;
   logic [IdxW-1:0]       r_bit_idx, w_bit_idx_d;
   logic                  r_stop_idx, w_stop_idx_d;
   logic                  r_serial, w_serial_d;
   logic                  r_active, w_active_d;
   logic                  r_ready, w_ready_d;
   logic                  r_done, w_done_d;
   logic                  w_accept;
   logic                  w_tick;

`ifdef UART_TX_PARITY_EN
   logic r_par_en, w_par_en_d;
   logic r_par_bit, w_par_bit_d;
`else
   logic w_unused_parity;
   assign w_unused_parity = parityEn ^ parityOdd;
`endif

   assign w_accept = txDv && r_ready;

   uart_baud_counter #(
      .CPB_WIDTH(CPB_WIDTH)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_accept),
      .i_run  (r_active),
      .i_cpb  (clocksPerBit),
      .bitTick(w_tick)
   );

   always_comb begin
      w_state_d    = r_state;
      w_shift_d    = r_shift;
      w_byte_d     = r_byte;
      w_bit_idx_d  = r_bit_idx;
      w_stop_idx_d = r_stop_idx;
      w_serial_d   = r_serial;
      w_active_d   = r_active;
      w_ready_d    = r_ready;
      w_done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_en_d   = r_par_en;
      w_par_bit_d  = r_par_bit;
`endif
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_d   = START;
               w_shift_d   = txData;
               w_byte_d    = txData;
               w_bit_idx_d = '0;
               w_serial_d  = 1'b0;
               w_active_d  = 1'b1;
               w_ready_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
               w_par_en_d  = parityEn;
               w_par_bit_d = (^txData) ^ parityOdd;
`endif
            end
         end
         START: begin
            if (w_tick) begin
               w_state_d  = DATA;
               w_serial_d = r_shift[0];
            end
         end
         DATA: begin
            if (w_tick) begin
               if (r_bit_idx == IdxW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                  if (r_par_en) begin
                     w_state_d  = PARITY;
                     w_serial_d = r_par_bit;
                  end else begin
                     w_state_d  = STOP;
                     w_serial_d = UART_LINE_IDLE;
                  end
`else
                  w_state_d  = STOP;
                  w_serial_d = UART_LINE_IDLE;
`endif
                  w_stop_idx_d = 1'b0;
               end else begin
                  // Shift register keeps the next bit at index 1.
                  w_bit_idx_d = r_bit_idx + IdxW'(1);
                  w_shift_d   = r_shift >> 1;
                  w_serial_d  = r_shift[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_tick) begin
               w_state_d  = STOP;
               w_serial_d = UART_LINE_IDLE;
            end
         end
`endif
         STOP: begin
            if (w_tick) begin
               if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                  w_state_d  = IDLE;
                  w_active_d = 1'b0;
                  w_ready_d  = 1'b1;
                  w_done_d   = 1'b1;
               end else begin
                  w_stop_idx_d = 1'b1;
               end
            end
         end
         default: begin
            w_state_d  = IDLE;
            w_serial_d = UART_LINE_IDLE;
            w_active_d = 1'b0;
            w_ready_d  = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_byte     <= '0;
         r_bit_idx  <= '0;
         r_stop_idx <= 1'b0;
         r_serial   <= UART_LINE_IDLE;
         r_active   <= 1'b0;
         r_ready    <= 1'b1;
         r_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_d;
         r_shift    <= w_shift_d;
         r_byte     <= w_byte_d;
         r_bit_idx  <= w_bit_idx_d;
         r_stop_idx <= w_stop_idx_d;
         r_serial   <= w_serial_d;
         r_active   <= w_active_d;
         r_ready    <= w_ready_d;
         r_done     <= w_done_d;
`ifdef UART_TX_PARITY_EN
         r_par_en   <= w_par_en_d;
         r_par_bit  <= w_par_bit_d;
`endif
      end
   end

   assign txReady  = r_ready;
   assign txActive = r_active;
   assign txDone   = r_done;
   assign txSerial = r_serial;
   assign txByte   = r_byte;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8N1 instance and a 5-bit/2-stop instance checked
// against a frame-level bit-list model. Parity expectations follow `UART_TX_PARITY_EN.
module tb_uart_tx_frame;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] cpb_in;
   logic        par_en, par_odd;
   logic        dv_a, dv_b;
   logic [7:0]  data_a;
   logic [4:0]  data_b;
   logic        rdy_a, act_a, done_a, ser_a;
   logic        rdy_b, act_b, done_b, ser_b;
   logic [7:0]  byte_a;
   logic [4:0]  byte_b;
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx_frame #(.DATA_WIDTH(8), .STOP_BITS(1), .CPB_WIDTH(32)) dut_a (
      .clk(clk), .reset(reset), .txDv(dv_a), .txData(data_a), .clocksPerBit(cpb_in),
      .parityEn(par_en), .parityOdd(par_odd), .txReady(rdy_a), .txActive(act_a),
      .txDone(done_a), .txSerial(ser_a), .txByte(byte_a)
   );

   uart_tx_frame #(.DATA_WIDTH(5), .STOP_BITS(2), .CPB_WIDTH(32)) dut_b (
      .clk(clk), .reset(reset), .txDv(dv_b), .txData(data_b), .clocksPerBit(cpb_in),
      .parityEn(par_en), .parityOdd(par_odd), .txReady(rdy_b), .txActive(act_b),
      .txDone(done_b), .txSerial(ser_b), .txByte(byte_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference frame as a list of line levels, one entry per bit period.
   task automatic build_frame(input int dw, input int stops, input logic [8:0] d, input bit pe,
                              input bit po, output logic [15:0] fb, output int n);
      logic p;
      fb = '1;
      n  = 0;
      p  = po;
      fb[n] = 1'b0;
      n++;
      for (int i = 0; i < dw; i++) begin
         fb[n] = d[i];
         p     = p ^ d[i];
         n++;
      end
      if (pe) begin
         fb[n] = p;
         n++;
      end
      n = n + stops;
   endtask

   task automatic send_frame(input bit sel, input logic [8:0] d, input int cpb, input bit pe,
                             input bit po, input bit hold, input logic [8:0] nd);
      int          dw, stops, eff, n;
      bit          pe_eff;
      logic [15:0] fb;
      logic [8:0]  mask;
      dw    = sel ? 5 : 8;
      stops = sel ? 2 : 1;
      eff   = (cpb < 2) ? 2 : cpb;
      mask  = 9'((1 << dw) - 1);
`ifdef UART_TX_PARITY_EN
      pe_eff = pe;
`else
      pe_eff = 1'b0;
`endif
      build_frame(dw, stops, d, pe_eff, po, fb, n);
      check("ready_before_accept", 32'(sel ? rdy_b : rdy_a), 32'd1);
      if (sel) begin dv_b = 1'b1; data_b = d[4:0]; end
      else     begin dv_a = 1'b1; data_a = d[7:0]; end
      cpb_in  = 32'(cpb);
      par_en  = pe;
      par_odd = po;
      @(posedge clk); #1;
      // Disturb every sampled input after the accept edge.
      cpb_in  = $urandom;
      par_en  = 1'($urandom);
      par_odd = 1'($urandom);
      if (sel) begin dv_b = hold; data_b = hold ? nd[4:0] : 5'($urandom); end
      else     begin dv_a = hold; data_a = hold ? nd[7:0] : 8'($urandom); end
      for (int t = 0; t <= n * eff; t++) begin
         if (t > 0) begin @(posedge clk); #1; end
         check("serial", 32'(sel ? ser_b : ser_a), 32'((t < n * eff) ? fb[t / eff] : 1'b1));
         check("done",   32'(sel ? done_b : done_a), 32'(t == n * eff));
         check("active", 32'(sel ? act_b : act_a), 32'(t < n * eff));
         check("ready",  32'(sel ? rdy_b : rdy_a), 32'(t == n * eff));
      end
      check("txByte", sel ? 32'(byte_b) : 32'(byte_a), 32'(d & mask));
   endtask

   initial begin
      reset   = 1'b1;
      dv_a    = 1'b0;
      dv_b    = 1'b0;
      data_a  = '0;
      data_b  = '0;
      cpb_in  = 32'd4;
      par_en  = 1'b0;
      par_odd = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_serial_a", 32'(ser_a), 32'd1);
      check("rst_active_a", 32'(act_a), 32'd0);
      check("rst_done_a",   32'(done_a), 32'd0);
      check("rst_ready_a",  32'(rdy_a), 32'd1);
      check("rst_byte_a",   32'(byte_a), 32'd0);
      check("rst_serial_b", 32'(ser_b), 32'd1);
      check("rst_ready_b",  32'(rdy_b), 32'd1);
      check("rst_byte_b",   32'(byte_b), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // 8N1 basic frame, parity frames, 5-bit two-stop frame.
      send_frame(1'b0, 9'h07, 4, 1'b0, 1'b0, 1'b0, 9'h0);
      send_frame(1'b0, 9'h07, 5, 1'b1, 1'b0, 1'b0, 9'h0);
      send_frame(1'b0, 9'h07, 5, 1'b1, 1'b1, 1'b0, 9'h0);
      send_frame(1'b1, 9'h15, 3, 1'b0, 1'b0, 1'b0, 9'h0);

      // Back-to-back with txDv held high through the done cycle.
      send_frame(1'b0, 9'hA5, 4, 1'b0, 1'b0, 1'b1, 9'h3C);
      send_frame(1'b0, 9'h3C, 4, 1'b0, 1'b0, 1'b0, 9'h0);

      // Reset during the DATA phase.
      dv_a   = 1'b1;
      data_a = 8'hC3;
      cpb_in = 32'd4;
      par_en = 1'b0;
      @(posedge clk); #1;
      dv_a = 1'b0;
      repeat (12) begin @(posedge clk); #1; end
      check("mid_serial", 32'(ser_a), 32'd0);
      check("mid_active", 32'(act_a), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("rst_mid_serial", 32'(ser_a), 32'd1);
      check("rst_mid_ready",  32'(rdy_a), 32'd1);
      check("rst_mid_active", 32'(act_a), 32'd0);
      check("rst_mid_done",   32'(done_a), 32'd0);
      send_frame(1'b0, 9'(($urandom)), 3, 1'b0, 1'b0, 1'b0, 9'h0);

      // Reset wins over a simultaneous request.
      reset  = 1'b1;
      dv_a   = 1'b1;
      data_a = 8'h5A;
      @(posedge clk); #1;
      reset = 1'b0;
      dv_a  = 1'b0;
      check("prio_ready",  32'(rdy_a), 32'd1);
      check("prio_active", 32'(act_a), 32'd0);
      check("prio_serial", 32'(ser_a), 32'd1);
      check("prio_byte",   32'(byte_a), 32'd0);

      // Short bit periods clamp to two clocks.
      send_frame(1'b0, 9'($urandom), 0, 1'b0, 1'b0, 1'b0, 9'h0);
      send_frame(1'b1, 9'($urandom), 1, 1'b0, 1'b0, 1'b0, 9'h0);

      for (int k = 0; k < 8; k++) begin
         send_frame(1'($urandom), 9'($urandom), int'($urandom_range(0, 6)), 1'($urandom),
                    1'($urandom), 1'b0, 9'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmitter, successor to the fixed 8N1 `uart_tx`. It serialises one word per `txDv` handshake at a runtime-selected bit period, with configurable data width, stop-bit count and optional parity. It sits between the byte source and the `txSerial` pad and drives the same line that `uart_rx` samples.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, 1: stop bits per frame; legal values 1 or 2.
- `CPB_WIDTH`, 32: width of `clocksPerBit`.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `txDv` in 1: request to send `txData`.
- `txData` in DATA_WIDTH: word to send; sampled only on accept.
- `clocksPerBit` in CPB_WIDTH: bit period in `clk` cycles; sampled only on accept.
- `parityEn` in 1: include a parity bit; sampled on accept.
- `parityOdd` in 1: 1 selects odd parity, 0 selects even; sampled on accept.
- `txReady` out 1: idle and able to accept.
- `txActive` out 1: frame in progress.
- `txDone` out 1: one-cycle pulse at frame end.
- `txSerial` out 1: serial line; idles high.
- `txByte` out DATA_WIDTH: copy of the last accepted word.

## Operation
- Accept occurs at a rising edge where `txDv && txReady`. On accept the block latches `txData`, `clocksPerBit`, `parityEn` and `parityOdd`. `txData` may change freely after that edge.
- A latched `clocksPerBit` value below 2 is treated as 2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE goes to START on accept.
  - START goes to DATA after one bit period.
  - DATA sends bits LSB first. A bit index counts 0..DATA_WIDTH-1. After the last bit the FSM goes to PARITY if parity is enabled, otherwise to STOP.
  - PARITY goes to STOP after one bit period.
  - STOP holds for STOP_BITS bit periods, then returns to IDLE.
- Line levels: START drives 0; DATA drives the current bit; STOP and IDLE drive 1.
- Parity bit: XOR of all data bits, inverted when `parityOdd` is 1.
- Bit-period counter: counts 0..cpb-1 and wraps to 0 at each bit boundary.
- Frame bit count N = 1 + DATA_WIDTH + P + STOP_BITS, where P is 1 with parity enabled, else 0.
- `txByte` updates on accept and holds until the next accept.
- Requests while busy: `txDv` during a frame is ignored. There is no queue.
- Reset mid-frame:
  - On the next edge the block returns to IDLE with `txSerial`=1, `txActive`=0 and `txReady`=1.
  - `txDone` is not pulsed and the frame is truncated.
  - `reset` takes priority over a simultaneous `txDv`.

## Timing
- All outputs are registered.
- Reset values: `txSerial`=1, `txActive`=0, `txDone`=0, `txReady`=1, `txByte`=0.
- Accept at edge E0:
  - From E0: `txSerial`=0, `txActive`=1, `txReady`=0.
  - `txSerial` changes only at edges E0 + n·cpb, for n = 1..N−1.
- Frame end at edge E0 + N·cpb:
  - `txDone`=1 for exactly one cycle.
  - `txActive`=0, `txReady`=1, `txSerial`=1.
- Back-to-back frames:
  - A `txDv` held high through the done cycle is accepted at the next edge.
  - The resulting inter-frame gap is exactly 1 clock of extra stop level.
- Latency from accept to the leading edge of the start bit: 0 cycles, because the line goes low at the accept edge.

## Configuration
- Macro: `UART_TX_PARITY_EN`.
- Defined: PARITY state and parity logic are present, and `parityEn`/`parityOdd` behave as above.
- Not defined:
  - PARITY state and parity logic are removed, so P is always 0.
  - `parityEn` and `parityOdd` stay on the port list but are ignored.

## Structure
- Package `uart_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_LINE_IDLE` = 1'b1;
  - `UART_MIN_CPB` = 2.
- Sub-module `uart_baud_counter`:
  - loads the latched cpb;
  - asserts `bitTick` on the last cycle of each bit period;
  - is cleared by `reset` and on accept.
- The FSM, shift register and parity logic live in the top module.

## Test plan
1. 8N1, cpb=4, `txData`=0x07 → line 0,1,1,1,0,0,0,0,0,1, each level for 4 cycles; `txDone` at E0+40; `txByte`=0x07.
2. Parity compiled in, `parityEn`=1, `parityOdd`=0, 0x07 → parity bit 1. With `parityOdd`=1 → parity bit 0. Frame length 11·cpb.
3. DATA_WIDTH=5, STOP_BITS=2, cpb=3, data 0x15 → line 0,1,0,1,0,1,1,1, each level for 3 cycles; `txDone` at E0+24.
4. `txDv` held high, data 0xA5 then 0x3C → two frames separated by 1 extra idle-high clock. `txDone` pulses twice. The second `txByte`=0x3C.
5. `reset` asserted at E0+13 during DATA → `txSerial`=1 and `txReady`=1 at the next edge; no `txDone`. A new request is accepted on the following cycle.
6. cpb=0 and cpb=1 → each bit lasts 2 cycles. `txData` changed mid-frame → transmitted bits are unaffected.
